// File: rtl/prf_rt.sv
// Physical register file with per-tag ready table and registered read channels.
// Define PRF_WR_BYPASS_EN to forward same-cycle CDB writes into reads and ready queries.
module prf_rt #(
    parameter int DATA_W    = 32,
    parameter int PRF_DEPTH = 64,
    parameter int N_WR      = 2,
    parameter int N_RD      = 2,
    parameter int N_ALLOC   = 1,
    parameter int TAG_W     = $clog2(PRF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_WR-1:0]       wr_valid,
    input  logic [TAG_W-1:0]      wr_tag      [N_WR],
    input  logic [DATA_W-1:0]     wr_data     [N_WR],
    input  logic [N_ALLOC-1:0]    alloc_valid,
    input  logic [TAG_W-1:0]      alloc_tag   [N_ALLOC],
    input  logic                  flush,
    input  logic [TAG_W-1:0]      rdy_tag     [N_RD*2],
    output logic [N_RD*2-1:0]     rdy_out,
    input  logic [N_RD-1:0]       rd_req,
    input  logic [TAG_W-1:0]      rd_rs1_tag  [N_RD],
    input  logic [TAG_W-1:0]      rd_rs2_tag  [N_RD],
    output logic [N_RD-1:0]       rd_resp,
    output logic [DATA_W-1:0]     rd_rs1_val  [N_RD],
    output logic [DATA_W-1:0]     rd_rs2_val  [N_RD]
);

    localparam int N_OPS = N_RD * 2;

    logic [DATA_W-1:0]    data_q    [PRF_DEPTH];
    logic [DATA_W-1:0]    data_d    [PRF_DEPTH];
    logic [PRF_DEPTH-1:0] ready_q;
    logic [PRF_DEPTH-1:0] ready_d;
    logic [N_RD-1:0]      rd_resp_q;
    logic [N_RD-1:0]      rd_resp_d;
    logic [DATA_W-1:0]    rs1_val_q [N_RD];
    logic [DATA_W-1:0]    rs1_val_d [N_RD];
    logic [DATA_W-1:0]    rs2_val_q [N_RD];
    logic [DATA_W-1:0]    rs2_val_d [N_RD];
    logic [TAG_W-1:0]     op_tag    [N_OPS];
    logic [DATA_W-1:0]    op_val    [N_OPS];

    // Ascending port order lets the highest-index writer win on a tag clash.
    always_comb begin
        for (int t = 0; t < PRF_DEPTH; t++) begin
            data_d[t] = data_q[t];
        end
        for (int w = 0; w < N_WR; w++) begin
            if (wr_valid[w] && wr_tag[w] != '0) begin
                data_d[wr_tag[w]] = wr_data[w];
            end
        end
        data_d[0] = '0;
    end

    // Priority: flush over alloc over write; tag 0 is pinned ready.
    always_comb begin
        ready_d = ready_q;
        for (int w = 0; w < N_WR; w++) begin
            if (wr_valid[w] && wr_tag[w] != '0) begin
                ready_d[wr_tag[w]] = 1'b1;
            end
        end
        for (int a = 0; a < N_ALLOC; a++) begin
            if (alloc_valid[a] && alloc_tag[a] != '0) begin
                ready_d[alloc_tag[a]] = 1'b0;
            end
        end
        if (flush) begin
            ready_d = '1;
        end
        ready_d[0] = 1'b1;
    end

    always_comb begin
        rdy_out = '0;
        for (int q = 0; q < N_OPS; q++) begin
            rdy_out[q] = ready_q[rdy_tag[q]];
`ifdef PRF_WR_BYPASS_EN
            for (int w = 0; w < N_WR; w++) begin
                if (wr_valid[w] && wr_tag[w] != '0 &&
                    wr_tag[w] == rdy_tag[q]) begin
                    rdy_out[q] = 1'b1;
                end
            end
`endif
        end
    end

    // Even slots carry rs1, odd slots rs2 of the same channel.
    always_comb begin
        for (int i = 0; i < N_RD; i++) begin
            op_tag[2*i]   = rd_rs1_tag[i];
            op_tag[2*i+1] = rd_rs2_tag[i];
        end
    end

    always_comb begin
        for (int j = 0; j < N_OPS; j++) begin
            op_val[j] = data_q[op_tag[j]];
`ifdef PRF_WR_BYPASS_EN
            for (int w = 0; w < N_WR; w++) begin
                if (wr_valid[w] && wr_tag[w] == op_tag[j]) begin
                    op_val[j] = wr_data[w];
                end
            end
`endif
            if (op_tag[j] == '0) begin
                op_val[j] = '0;
            end
        end
    end

    always_comb begin
        rd_resp_d = rd_req & ~{N_RD{flush}};
        for (int i = 0; i < N_RD; i++) begin
            rs1_val_d[i] = rs1_val_q[i];
            rs2_val_d[i] = rs2_val_q[i];
            if (rd_req[i]) begin
                rs1_val_d[i] = op_val[2*i];
                rs2_val_d[i] = op_val[2*i+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q   <= '1;
            rd_resp_q <= '0;
            for (int i = 0; i < N_RD; i++) begin
                rs1_val_q[i] <= '0;
                rs2_val_q[i] <= '0;
            end
        end else begin
            ready_q   <= ready_d;
            rd_resp_q <= rd_resp_d;
            rs1_val_q <= rs1_val_d;
            rs2_val_q <= rs2_val_d;
        end
    end

    assign rd_resp    = rd_resp_q;
    assign rd_rs1_val = rs1_val_q;
    assign rd_rs2_val = rs2_val_q;

endmodule

// File: tb/tb_prf_rt.sv
// Directed-vector bench for prf_rt; expectations follow PRF_WR_BYPASS_EN.
module tb_prf_rt;

    localparam int DATA_W    = 32;
    localparam int PRF_DEPTH = 64;
    localparam int N_WR      = 2;
    localparam int N_RD      = 2;
    localparam int N_ALLOC   = 1;
    localparam int TAG_W     = 6;
`ifdef PRF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [N_WR-1:0]      wr_valid;
    logic [TAG_W-1:0]     wr_tag      [N_WR];
    logic [DATA_W-1:0]    wr_data     [N_WR];
    logic [N_ALLOC-1:0]   alloc_valid;
    logic [TAG_W-1:0]     alloc_tag   [N_ALLOC];
    logic                 flush;
    logic [TAG_W-1:0]     rdy_tag     [N_RD*2];
    logic [N_RD*2-1:0]    rdy_out;
    logic [N_RD-1:0]      rd_req;
    logic [TAG_W-1:0]     rd_rs1_tag  [N_RD];
    logic [TAG_W-1:0]     rd_rs2_tag  [N_RD];
    logic [N_RD-1:0]      rd_resp;
    logic [DATA_W-1:0]    rd_rs1_val  [N_RD];
    logic [DATA_W-1:0]    rd_rs2_val  [N_RD];

    int vectors;
    int miscompares;

    prf_rt #(
        .DATA_W(DATA_W), .PRF_DEPTH(PRF_DEPTH), .N_WR(N_WR),
        .N_RD(N_RD), .N_ALLOC(N_ALLOC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_tag(wr_tag), .wr_data(wr_data),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .flush(flush), .rdy_tag(rdy_tag), .rdy_out(rdy_out),
        .rd_req(rd_req), .rd_rs1_tag(rd_rs1_tag),
        .rd_rs2_tag(rd_rs2_tag), .rd_resp(rd_resp),
        .rd_rs1_val(rd_rs1_val), .rd_rs2_val(rd_rs2_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        wr_valid    = '0;
        alloc_valid = '0;
        flush       = 1'b0;
        rd_req      = '0;
        for (int i = 0; i < N_WR; i++) begin
            wr_tag[i]  = '0;
            wr_data[i] = '0;
        end
        alloc_tag[0] = '0;
        for (int i = 0; i < N_RD*2; i++) rdy_tag[i] = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_rs1_tag[i] = '0;
            rd_rs2_tag[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rd_req[0] = 1'b1;
        rd_rs1_tag[0] = 6'd0;
        rd_rs2_tag[0] = 6'd5;
        tick();
        vectors++;
        if (rd_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_resp: got %b expected 00", rd_resp);
        end
        vectors++;
        if (rd_rs1_val[0] !== 32'h0 || rd_rs2_val[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_vals: got %h/%h expected 0/0",
                     rd_rs1_val[0], rd_rs2_val[0]);
        end
        tick();
        rst_n = 1'b1;
        rdy_tag[0] = 6'd5;
        #1;
        vectors++;
        if (rdy_out[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready5: got %b expected 1", rdy_out[0]);
        end
        tick();
        vectors++;
        if (rd_resp !== 2'b01 || rd_rs1_val[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_read0: got resp %b val %h expected 01/0",
                     rd_resp, rd_rs1_val[0]);
        end
        idle();
    endtask

    task automatic test_bypass();
        wr_valid[0] = 1'b1;
        wr_tag[0]   = 6'd5;
        wr_data[0]  = 32'h1111_1111;
        tick();
        idle();
        wr_valid[1] = 1'b1;
        wr_tag[1]   = 6'd5;
        wr_data[1]  = 32'hDEAD_BEEF;
        rd_req[0]   = 1'b1;
        rd_rs1_tag[0] = 6'd5;
        rd_rs2_tag[0] = 6'd0;
        tick();
        vectors++;
        if (rd_resp[0] !== 1'b1 ||
            rd_rs1_val[0] !== (BYP ? 32'hDEAD_BEEF : 32'h1111_1111)) begin
            miscompares++;
            $display("FAIL bypass_same: got resp %b val %h expected 1/%h",
                     rd_resp[0], rd_rs1_val[0],
                     BYP ? 32'hDEAD_BEEF : 32'h1111_1111);
        end
        vectors++;
        if (rd_rs2_val[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL bypass_tag0: got %h expected 0", rd_rs2_val[0]);
        end
        idle();
        rd_req[0] = 1'b1;
        rd_rs1_tag[0] = 6'd5;
        tick();
        vectors++;
        if (rd_rs1_val[0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL bypass_next: got %h expected deadbeef",
                     rd_rs1_val[0]);
        end
        idle();
    endtask

    task automatic test_alloc();
        alloc_valid[0] = 1'b1;
        alloc_tag[0]   = 6'd9;
        rdy_tag[0]     = 6'd9;
        #1;
        vectors++;
        if (rdy_out[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL alloc_same: got %b expected 1", rdy_out[0]);
        end
        tick();
        alloc_valid[0] = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            vectors++;
            if (rdy_out[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL alloc_busy_t%0d: got %b expected 0",
                         c, rdy_out[0]);
            end
            tick();
        end
        wr_valid[0] = 1'b1;
        wr_tag[0]   = 6'd9;
        wr_data[0]  = 32'h0000_1234;
        #1;
        vectors++;
        if (rdy_out[0] !== BYP) begin
            miscompares++;
            $display("FAIL alloc_wake: got %b expected %b", rdy_out[0], BYP);
        end
        tick();
        wr_valid[0] = 1'b0;
        rd_req[1] = 1'b1;
        rd_rs2_tag[1] = 6'd9;
        #1;
        vectors++;
        if (rdy_out[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL alloc_ready: got %b expected 1", rdy_out[0]);
        end
        tick();
        vectors++;
        if (rd_resp !== 2'b10 || rd_rs2_val[1] !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL alloc_read: got resp %b val %h expected 10/1234",
                     rd_resp, rd_rs2_val[1]);
        end
        idle();
    endtask

    task automatic test_conflict();
        alloc_valid[0] = 1'b1;
        alloc_tag[0]   = 6'd12;
        wr_valid[0]    = 1'b1;
        wr_tag[0]      = 6'd12;
        wr_data[0]     = 32'h0000_0055;
        rdy_tag[1]     = 6'd12;
        tick();
        idle();
        rdy_tag[1] = 6'd12;
        #1;
        vectors++;
        if (rdy_out[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_ready12: got %b expected 0", rdy_out[1]);
        end
        wr_valid   = 2'b11;
        wr_tag[0]  = 6'd7;
        wr_data[0] = 32'h0000_000A;
        wr_tag[1]  = 6'd7;
        wr_data[1] = 32'h0000_000B;
        rd_req[0]  = 1'b1;
        rd_rs1_tag[0] = 6'd12;
        tick();
        vectors++;
        if (rd_rs1_val[0] !== 32'h0000_0055) begin
            miscompares++;
            $display("FAIL conflict_data12: got %h expected 55",
                     rd_rs1_val[0]);
        end
        idle();
        rd_req[0] = 1'b1;
        rd_rs2_tag[0] = 6'd7;
        tick();
        vectors++;
        if (rd_rs2_val[0] !== 32'h0000_000B) begin
            miscompares++;
            $display("FAIL conflict_hiport: got %h expected b",
                     rd_rs2_val[0]);
        end
        idle();
    endtask

    task automatic test_flush();
        alloc_valid[0] = 1'b1;
        alloc_tag[0]   = 6'd20;
        tick();
        idle();
        rdy_tag[0] = 6'd20;
        rdy_tag[1] = 6'd21;
        #1;
        vectors++;
        if (rdy_out[1:0] !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_pre: got %b expected 10", rdy_out[1:0]);
        end
        flush = 1'b1;
        alloc_valid[0] = 1'b1;
        alloc_tag[0]   = 6'd21;
        rd_req = 2'b11;
        rd_rs1_tag[0] = 6'd12;
        rd_rs1_tag[1] = 6'd7;
        tick();
        flush = 1'b0;
        alloc_valid[0] = 1'b0;
        rd_req = 2'b01;
        #1;
        vectors++;
        if (rd_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_kill: got %b expected 00", rd_resp);
        end
        vectors++;
        if (rdy_out[1:0] !== 2'b11) begin
            miscompares++;
            $display("FAIL flush_ready: got %b expected 11", rdy_out[1:0]);
        end
        tick();
        vectors++;
        if (rd_resp !== 2'b01 || rd_rs1_val[0] !== 32'h0000_0055) begin
            miscompares++;
            $display("FAIL flush_after: got resp %b val %h expected 01/55",
                     rd_resp, rd_rs1_val[0]);
        end
        idle();
    endtask

    task automatic test_tag0();
        wr_valid[1]    = 1'b1;
        wr_tag[1]      = 6'd0;
        wr_data[1]     = 32'hFFFF_FFFF;
        alloc_valid[0] = 1'b1;
        alloc_tag[0]   = 6'd0;
        rd_req[1]      = 1'b1;
        rd_rs1_tag[1]  = 6'd0;
        rd_rs2_tag[1]  = 6'd0;
        rdy_tag[2]     = 6'd0;
        tick();
        vectors++;
        if (rd_rs1_val[1] !== 32'h0 || rd_rs2_val[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL tag0_same: got %h/%h expected 0/0",
                     rd_rs1_val[1], rd_rs2_val[1]);
        end
        wr_valid = '0;
        alloc_valid = '0;
        #1;
        vectors++;
        if (rdy_out[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL tag0_ready: got %b expected 1", rdy_out[2]);
        end
        tick();
        vectors++;
        if (rd_resp[1] !== 1'b1 || rd_rs1_val[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL tag0_after: got resp %b val %h expected 1/0",
                     rd_resp[1], rd_rs1_val[1]);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        wr_valid = 2'b11;
        wr_tag[0] = 6'd30;
        wr_data[0] = 32'h3030_3030;
        wr_tag[1] = 6'd31;
        wr_data[1] = 32'h3131_3131;
        tick();
        idle();
        rd_req[0] = 1'b1;
        rd_rs1_tag[0] = 6'd30;
        tick();
        vectors++;
        if (rd_resp[0] !== 1'b1 || rd_rs1_val[0] !== 32'h3030_3030) begin
            miscompares++;
            $display("FAIL b2b_first: got resp %b val %h expected 1/30303030",
                     rd_resp[0], rd_rs1_val[0]);
        end
        rd_rs1_tag[0] = 6'd31;
        tick();
        vectors++;
        if (rd_resp[0] !== 1'b1 || rd_rs1_val[0] !== 32'h3131_3131) begin
            miscompares++;
            $display("FAIL b2b_second: got resp %b val %h expected 1/31313131",
                     rd_resp[0], rd_rs1_val[0]);
        end
        rd_req[0] = 1'b0;
        rd_rs1_tag[0] = 6'd30;
        tick();
        vectors++;
        if (rd_resp[0] !== 1'b0 || rd_rs1_val[0] !== 32'h3131_3131) begin
            miscompares++;
            $display("FAIL b2b_hold: got resp %b val %h expected 0/31313131",
                     rd_resp[0], rd_rs1_val[0]);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        alloc_valid[0] = 1'b1;
        alloc_tag[0]   = 6'd40;
        rd_req[0] = 1'b1;
        rd_rs1_tag[0] = 6'd31;
        tick();
        idle();
        rst_n = 1'b0;
        rd_req = 2'b11;
        rd_rs1_tag[0] = 6'd30;
        tick();
        vectors++;
        if (rd_resp !== 2'b00 || rd_rs1_val[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_kill: got resp %b val %h expected 00/0",
                     rd_resp, rd_rs1_val[0]);
        end
        rst_n = 1'b1;
        rd_req = '0;
        rdy_tag[3] = 6'd40;
        #1;
        vectors++;
        if (rdy_out[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: got %b expected 1", rdy_out[3]);
        end
        tick();
        vectors++;
        if (rd_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_idle: got %b expected 00", rd_resp);
        end
        idle();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_bypass();
        test_alloc();
        test_conflict();
        test_flush();
        test_tag0();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
